// File: rtl/snake_pkg.sv
// Shared direction encoding and IR remote command codes for the snake game blocks.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam logic [7:0] IR_UP    = 8'h18;
  localparam logic [7:0] IR_DOWN  = 8'h52;
  localparam logic [7:0] IR_LEFT  = 8'h08;
  localparam logic [7:0] IR_RIGHT = 8'h5A;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } dir_req_t;

  // Opposite directions differ only in bit 0 with this encoding.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return a == (b ^ 2'b01);
  endfunction

  function automatic dir_req_t ir_decode(input logic [7:0] code);
    dir_req_t r;
    r.valid = 1'b1;
    r.dir   = DIR_UP;
    case (code)
      IR_UP:    r.dir = DIR_UP;
      IR_DOWN:  r.dir = DIR_DOWN;
      IR_LEFT:  r.dir = DIR_LEFT;
      IR_RIGHT: r.dir = DIR_RIGHT;
      default:  r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular buffer of pending turns; exposes both head (next to apply) and tail (last queued).
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  dir_t          push_dir,
  output dir_t          head,
  output dir_t          tail,
  output logic [CW-1:0] count,
  output logic          full
);

  dir_t          mem_q [DEPTH];
  dir_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign tail  = mem_q[ptr_dec(wr_ptr_q)];

  // A full buffer still takes a push when a pop frees a slot on the same edge.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dir;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: DIR_UP};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/snake_dir_sched.sv
// Direction scheduler: arbitrates key/IR turn requests, filters duplicates and reversals,
// queues accepted turns and applies one per speed-dependent move tick.
module snake_dir_sched
  import snake_pkg::*;
#(
  parameter int unsigned TICK_BASE = 6_250_000,
  parameter int unsigned TICK_STEP = 500_000,
  parameter int unsigned SPEED_MAX = 7,
  parameter int          QDEPTH    = 4,
  parameter dir_t        DIR_INIT  = DIR_RIGHT,
  localparam int         QCW       = $clog2(QDEPTH + 1)
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           kf_up,
  input  logic           kf_down,
  input  logic           kf_left,
  input  logic           kf_right,
  input  logic           ir_data_en,
  input  logic [7:0]     ir_data,
  input  logic           ir_repeat_en,
  input  logic           game_run,
  input  logic           game_restart,
  input  logic           speed_up,
  output logic           move_tick,
  output dir_t           move_dir,
  output logic [2:0]     speed_level,
  output logic [QCW-1:0] q_count,
  output logic           req_drop
);

  localparam int CW = $clog2(TICK_BASE);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  period, last_cnt;
  logic           move_tick_q, move_tick_d;
  dir_t           move_dir_q, move_dir_d;
  logic [2:0]     speed_q, speed_d;
  logic           req_drop_q, req_drop_d;

  dir_req_t       ir_req;
  logic           ir_valid;
  logic [4:0]     req_vec;
  logic           win_valid, multi_req;
  dir_t           win_dir, ref_dir;
  logic           tick_fire, pop, accept;

  dir_t           fifo_head, fifo_tail;
  logic [QCW-1:0] fifo_count;
  logic           fifo_full;

  logic           unused_ir_repeat;
  assign unused_ir_repeat = ir_repeat_en;

  assign ir_req   = ir_decode(ir_data);
  assign ir_valid = ir_data_en && ir_req.valid;
  assign req_vec  = {ir_valid, kf_right, kf_left, kf_down, kf_up};
  assign period   = CW'(TICK_BASE) - CW'(speed_q) * CW'(TICK_STEP);
  assign last_cnt = period - CW'(1);

  // Fixed priority: keys in up/down/left/right order, IR last.
  always_comb begin
    win_valid = 1'b1;
    win_dir   = DIR_UP;
    if (kf_up)          win_dir = DIR_UP;
    else if (kf_down)   win_dir = DIR_DOWN;
    else if (kf_left)   win_dir = DIR_LEFT;
    else if (kf_right)  win_dir = DIR_RIGHT;
    else if (ir_valid)  win_dir = ir_req.dir;
    else                win_valid = 1'b0;
    multi_req = (req_vec & (req_vec - 5'd1)) != '0;
  end

  // The filter compares against the last queued turn so chained turns are checked in order.
  always_comb begin
    tick_fire = game_run && (cnt_q >= last_cnt);
    pop       = tick_fire && (fifo_count != '0);
    ref_dir   = (fifo_count != '0) ? fifo_tail : move_dir_q;
    accept    = 1'b0;
    req_drop_d = 1'b0;
    if (game_run && win_valid) begin
      if ((win_dir == ref_dir) || is_reverse(win_dir, ref_dir) || (fifo_full && !pop)) begin
        req_drop_d = 1'b1;
      end else begin
        accept = 1'b1;
      end
      if (multi_req) req_drop_d = 1'b1;
    end

    cnt_d       = cnt_q;
    move_tick_d = 1'b0;
    move_dir_d  = move_dir_q;
    speed_d     = speed_q;
    if (game_run) begin
      if (tick_fire) begin
        cnt_d       = '0;
        move_tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (pop) move_dir_d = fifo_head;
    if (speed_up && (speed_q != 3'(SPEED_MAX))) speed_d = speed_q + 3'd1;

    if (game_restart) begin
      cnt_d       = '0;
      move_tick_d = 1'b0;
      move_dir_d  = DIR_INIT;
      speed_d     = '0;
      req_drop_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= '0;
      move_tick_q <= 1'b0;
      move_dir_q  <= DIR_INIT;
      speed_q     <= '0;
      req_drop_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      move_tick_q <= move_tick_d;
      move_dir_q  <= move_dir_d;
      speed_q     <= speed_d;
      req_drop_q  <= req_drop_d;
    end
  end

  dir_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .flush    (game_restart),
    .push     (accept && !game_restart),
    .pop      (pop && !game_restart),
    .push_dir (win_dir),
    .head     (fifo_head),
    .tail     (fifo_tail),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  assign move_tick   = move_tick_q;
  assign move_dir    = move_dir_q;
  assign speed_level = speed_q;
  assign q_count     = fifo_count;
  assign req_drop    = req_drop_q;

endmodule

// File: tb/tb_snake_dir_sched.sv
// Scoreboard bench for snake_dir_sched: expected ticks/drops are queued with their cycle,
// a negedge monitor pops and compares them whenever the DUT pulses move_tick or req_drop.
`timescale 1ns/1ps
module tb_snake_dir_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kf_up, kf_down, kf_left, kf_right;
  logic       ir_data_en, ir_repeat_en;
  logic [7:0] ir_data;
  logic       game_run, game_restart, speed_up;
  logic       move_tick, req_drop;
  logic [1:0] move_dir;
  logic [2:0] speed_level, q_count;

  snake_dir_sched #(
    .TICK_BASE(20), .TICK_STEP(2), .SPEED_MAX(7), .QDEPTH(4), .DIR_INIT(2'd3)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .kf_up(kf_up), .kf_down(kf_down), .kf_left(kf_left), .kf_right(kf_right),
    .ir_data_en(ir_data_en), .ir_data(ir_data), .ir_repeat_en(ir_repeat_en),
    .game_run(game_run), .game_restart(game_restart), .speed_up(speed_up),
    .move_tick(move_tick), .move_dir(move_dir), .speed_level(speed_level),
    .q_count(q_count), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] dir;
  } tick_exp_t;

  tick_exp_t tick_q[$];
  int        drop_q[$];
  int        n_checks = 0;
  int        n_fail = 0;

  function automatic void checkVal(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every output pulse must match the oldest expectation
  always @(negedge clk) begin
    tick_exp_t e;
    int        d;
    if (move_tick) begin
      if (tick_q.size() == 0) checkVal("unexpected_tick", cyc, -1);
      else begin
        e = tick_q.pop_front();
        checkVal("tick_cycle", cyc, e.at);
        checkVal("tick_dir", int'(move_dir), int'(e.dir));
      end
    end
    if (req_drop) begin
      if (drop_q.size() == 0) checkVal("unexpected_drop", cyc, -1);
      else begin
        d = drop_q.pop_front();
        checkVal("drop_cycle", cyc, d);
      end
    end
  end

  task automatic waitTo(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  task automatic expectTick(input int at, input logic [1:0] dir);
    tick_exp_t e;
    e.at  = at;
    e.dir = dir;
    tick_q.push_back(e);
  endtask

  // kf bits: [0]=up [1]=down [2]=left [3]=right; inputs are sampled at edge 'at'
  task automatic applyStimulus(input int at, input logic [3:0] kf, input logic ir_en,
                               input logic [7:0] ir, input logic ir_rep, input logic spd,
                               input logic exp_drop);
    waitTo(at - 1);
    if (cyc != at - 1) checkVal("schedule", cyc, at - 1);
    {kf_right, kf_left, kf_down, kf_up} = kf;
    ir_data_en   = ir_en;
    ir_data      = ir;
    ir_repeat_en = ir_rep;
    speed_up     = spd;
    if (exp_drop) drop_q.push_back(at);
    @(negedge clk);
    {kf_right, kf_left, kf_down, kf_up} = 4'b0;
    ir_data_en   = 1'b0;
    ir_data      = 8'h00;
    ir_repeat_en = 1'b0;
    speed_up     = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int dir, input int spd, input int q);
    checkVal({name, "_dir"}, int'(move_dir), dir);
    checkVal({name, "_speed"}, int'(speed_level), spd);
    checkVal({name, "_qcount"}, int'(q_count), q);
  endtask

  task automatic checkReset(input string name);
    checkVal({name, "_tick"}, int'(move_tick), 0);
    checkVal({name, "_drop"}, int'(req_drop), 0);
    checkOutput(name, 3, 0, 0);
  endtask

  task automatic doRestart(output int base);
    game_restart = 1'b1;
    base = cyc + 1;
    @(negedge clk);
    game_restart = 1'b0;
    checkReset("restart");
  endtask

  int b;

  initial begin
    rst_n = 1'b0;
    {kf_up, kf_down, kf_left, kf_right} = 4'b0;
    ir_data_en = 1'b0; ir_data = 8'h00; ir_repeat_en = 1'b0;
    game_run = 1'b1; game_restart = 1'b0; speed_up = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    checkReset("reset");

    // free-running ticks, then an async reset mid-count restarts the period
    expectTick(b + 20, 2'd3); expectTick(b + 40, 2'd3); expectTick(b + 60, 2'd3);
    waitTo(b + 70);
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    checkReset("async_reset");
    expectTick(b + 20, 2'd3);
    waitTo(b + 20);

    // reversal, push, duplicate
    doRestart(b);
    applyStimulus(b + 2, 4'b0100, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("reversal", 3, 0, 0);
    applyStimulus(b + 5, 4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("push_up", 3, 0, 1);
    applyStimulus(b + 6, 4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("dup_up", 3, 0, 1);
    expectTick(b + 20, 2'd0);
    waitTo(b + 20);
    checkOutput("pop_up", 0, 0, 0);

    // arbitration and IR decoding
    doRestart(b);
    applyStimulus(b + 3, 4'b0010, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
    checkOutput("arb_down", 3, 0, 1);
    applyStimulus(b + 5, 4'b0000, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
    checkOutput("ir_repeat", 3, 0, 1);
    applyStimulus(b + 7, 4'b0000, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    checkOutput("ir_left", 3, 0, 2);
    applyStimulus(b + 9, 4'b0000, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checkOutput("ir_unknown", 3, 0, 2);
    expectTick(b + 20, 2'd1); expectTick(b + 40, 2'd2);
    waitTo(b + 20);
    checkOutput("pop_down", 1, 0, 1);
    waitTo(b + 40);
    checkOutput("pop_left", 2, 0, 0);

    // full queue: drop without pop, accept when a tick pops on the same edge
    doRestart(b);
    applyStimulus(b + 2, 4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(b + 3, 4'b0100, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(b + 4, 4'b0010, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(b + 5, 4'b0100, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("fill", 3, 0, 4);
    applyStimulus(b + 7, 4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("full_drop", 3, 0, 4);
    expectTick(b + 20, 2'd0); expectTick(b + 40, 2'd2);
    applyStimulus(b + 20, 4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("push_at_tick", 0, 0, 4);
    waitTo(b + 40);
    checkOutput("after_pop", 2, 0, 3);

    // speed saturation: counter 7 already past new P-1=5 -> tick at +8, then period 6
    doRestart(b);
    expectTick(b + 8, 2'd3); expectTick(b + 14, 2'd3); expectTick(b + 20, 2'd3);
    for (int k = 1; k <= 8; k++)
      applyStimulus(b + k, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("speed_sat", 3, 7, 0);
    waitTo(b + 20);

    // speed_up at counter 15 from level 0 -> period 18 from then on
    doRestart(b);
    expectTick(b + 18, 2'd3); expectTick(b + 36, 2'd3);
    applyStimulus(b + 16, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("speed_one", 3, 1, 0);
    waitTo(b + 36);

    // pause for 50 cycles: counter holds, requests ignored silently
    doRestart(b);
    waitTo(b + 10);
    game_run = 1'b0;
    applyStimulus(b + 30, 4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("paused_req", 3, 0, 0);
    waitTo(b + 60);
    game_run = 1'b1;
    expectTick(b + 70, 2'd3);
    waitTo(b + 70);

    // restart beats a same-cycle request and speed_up
    game_restart = 1'b1; kf_up = 1'b1; speed_up = 1'b1;
    b = cyc + 1;
    @(negedge clk);
    game_restart = 1'b0; kf_up = 1'b0; speed_up = 1'b0;
    checkReset("restart_wins");
    waitTo(b + 5);
    checkVal("pending_ticks", tick_q.size(), 0);
    checkVal("pending_drops", drop_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
